fifo_blk_ctrl: RTL and testbench

//  Synchronous FIFO controller that sequences an external ram_blk_dp instance
//  (1-cycle registered read) as first-word-fall-through storage. Owns write/read

---
 rtl/fifo_blk_ctrl.sv | 140 ++++++++++++++
 tb/tb_fifo_blk_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_blk_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_blk_ctrl
//   Synchronous first-word-fall-through FIFO controller that drives an external
//   dual-port block RAM with a 1-cycle registered read. The controller owns the
//   write/read pointers and the committed-word count. It prefetches RAM words
//   into a 2-entry output buffer (head + skid), which hides the read latency and
//   sustains one word per clock.
//
// Ports
//   clk, reset             single rising-edge clock, synchronous active-high reset
//   in_data/in_valid/      write stream; a word is accepted when in_valid && in_ready
//     in_ready
//   out_data/out_valid/    read stream; the head word is popped when
//     out_ready              out_valid && out_ready
//   level                  words held: RAM + in-flight read + output buffer
//   ram_we/ram_wr_addr/    RAM write port (address = write pointer)
//     ram_wr_data
//   ram_rd_addr            RAM read address (= read pointer), sampled every edge
//   ram_rd_data            RAM read data, valid one clock after the address is sampled
// -----------------------------------------------------------------------------
module fifo_blk_ctrl #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned ADDRWIDTH = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDRWIDTH+1:0] level,
  output logic                 ram_we,
  output logic [ADDRWIDTH-1:0] ram_wr_addr,
  output logic [DATAWIDTH-1:0] ram_wr_data,
  output logic [ADDRWIDTH-1:0] ram_rd_addr,
  input  logic [DATAWIDTH-1:0] ram_rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDRWIDTH;
  localparam int unsigned LVLW  = ADDRWIDTH + 1;  // ram_level spans 0..DEPTH
  localparam int unsigned TOTW  = ADDRWIDTH + 2;  // total level spans 0..DEPTH+2
  localparam logic [LVLW-1:0] RAM_FULL = LVLW'(DEPTH);

  logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVLW-1:0]      ram_level_q, ram_level_d;
  logic                 infl_q, infl_d;
  logic [DATAWIDTH-1:0] head_q, head_d;
  logic [DATAWIDTH-1:0] skid_q, skid_d;
  logic [1:0]           occ_q, occ_d;
  logic [TOTW-1:0]      level_q, level_d;

  logic       push;
  logic       pop;
  logic       rd_issue;
  logic [2:0] pending;  // output-buffer occupancy next cycle, before any new issue

  // Handshake outputs come straight from registered state (plus reset for in_ready).
  assign in_ready    = !reset && (ram_level_q != RAM_FULL);
  assign out_valid   = (occ_q != 2'd0);
  assign out_data    = head_q;
  assign level       = level_q;

  assign ram_we      = push;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_wr_data = in_data;
  assign ram_rd_addr = rd_ptr_q;

  // Next-state logic for pointers, counts and the output buffer.
  always_comb begin
    push        = in_valid && in_ready;
    pop         = out_valid && out_ready;
    pending     = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    // Issue only if the word will still have a slot when it lands next cycle.
    rd_issue    = (ram_level_q != '0) && (pending < 3'd2);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_level_d = ram_level_q;
    infl_d      = rd_issue;
    head_d      = head_q;
    skid_d      = skid_q;
    occ_d       = pending[1:0];

    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDRWIDTH'(1);
    end
    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + ADDRWIDTH'(1);
    end

    unique case ({push, rd_issue})
      2'b10:   ram_level_d = ram_level_q + LVLW'(1);
      2'b01:   ram_level_d = ram_level_q - LVLW'(1);
      default: ram_level_d = ram_level_q;
    endcase

    // Pop shifts skid into head; returning read data fills the first free slot.
    if (pop && (occ_q == 2'd2)) begin
      head_d = skid_q;
      if (infl_q) begin
        skid_d = ram_rd_data;
      end
    end else if (infl_q) begin
      if ((occ_q == 2'd0) || pop) begin
        head_d = ram_rd_data;
      end else begin
        skid_d = ram_rd_data;
      end
    end

    level_d = TOTW'(ram_level_d) + TOTW'(infl_d) + TOTW'(occ_d);
  end

  // State registers; reset also drops any read that is still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_level_q <= '0;
      infl_q      <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
      occ_q       <= 2'd0;
      level_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_level_q <= ram_level_d;
      infl_q      <= infl_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      occ_q       <= occ_d;
      level_q     <= level_d;
    end
  end

endmodule

// File: tb/tb_fifo_blk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_blk_ctrl
//   Bench for fifo_blk_ctrl with a behavioural 1-cycle-read RAM. Accepted words
//   are queued as expected results and compared in order when popped. The level
//   output is compared against the queue depth every cycle.
// -----------------------------------------------------------------------------
module tb_fifo_blk_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW+1:0] level;
  logic          ram_we;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data = '0;

  fifo_blk_ctrl #(
    .DATAWIDTH(DW),
    .ADDRWIDTH(AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .ram_we     (ram_we),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // Block RAM model: write-first irrelevant, read registered by one clock.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and monitor (negedge, away from the active edge).
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_word;
  logic [DW-1:0] last_pop_data = '0;
  int  cyc = 0;
  int  acc_total = 0;
  int  pop_total = 0;
  int  acc_cyc = 0;
  int  last_pop_cyc = 0;
  bit  acc_n = 1'b0;

  always @(negedge clk) begin
    cyc++;
    acc_n = 1'b0;
    if (reset) begin
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      sb.delete();
    end else begin
      check_eq("level", 32'(level), 32'(sb.size()));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("pop_on_empty", 32'(out_valid), 32'd0);
        end else begin
          exp_word = sb.pop_front();
          check_eq("data", 32'(out_data), 32'(exp_word));
        end
        pop_total++;
        last_pop_cyc  = cyc;
        last_pop_data = out_data;
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        acc_n = 1'b1;
        acc_total++;
        acc_cyc = cyc;
      end
    end
  end

  // Stimulus driver: incrementing source data, random or periodic sink.
  int unsigned   src_left  = 0;
  int unsigned   in_pct    = 0;
  int unsigned   out_pct   = 0;
  int unsigned   stall_per = 0;
  int unsigned   drv_cnt   = 0;
  logic [DW-1:0] src_data  = '0;

  always @(posedge clk) begin
    #1;
    drv_cnt++;
    if (acc_n) begin
      src_data++;
      src_left--;
    end
    in_valid = (src_left != 0) && ($urandom_range(99) < in_pct);
    in_data  = src_data;
    if (stall_per != 0) out_ready = (drv_cnt % stall_per) != 0;
    else                out_ready = $urandom_range(99) < out_pct;
  end

  task automatic wait_neg(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic wait_pops(input string tag, input int target, input int bound);
    int i;
    i = 0;
    while (pop_total < target && i < bound) begin
      wait_neg(1);
      i++;
    end
    check_eq(tag, 32'(pop_total >= target), 32'd1);
  endtask

  task automatic drain(input string tag, input int bound);
    int i;
    i = 0;
    while ((sb.size() != 0 || out_valid || src_left != 0) && i < bound) begin
      wait_neg(1);
      i++;
    end
    check_eq(tag, 32'(i < bound), 32'd1);
    check_eq({tag, "_level"}, 32'(level), 32'd0);
  endtask

  initial begin
    #1_000_000;
    check_eq("watchdog", 32'd1, 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  bit seen;
  int t0;
  int p0;
  int first_pop;

  initial begin
    void'($urandom(32'd2024));

    // Reset for three clocks.
    reset = 1'b1;
    wait_neg(3);
    reset = 1'b0;
    wait_neg(1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Single word: latency, data, level, then pop.
    src_data = 8'hA5; in_pct = 100; out_pct = 0; src_left = 1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      wait_neg(1);
      if (out_valid) seen = 1'b1;
    end
    check_eq("lat_seen", 32'(seen), 32'd1);
    check_eq("lat_edges", 32'(cyc - acc_cyc), 32'd3);
    check_eq("single_data", 32'(out_data), 32'hA5);
    check_eq("single_level", 32'(level), 32'd1);
    out_pct = 100;
    wait_neg(1);
    out_pct = 0;
    wait_neg(1);
    check_eq("single_pop_valid", 32'(out_valid), 32'd0);
    check_eq("single_pop_level", 32'(level), 32'd0);

    // Fill with sink stalled: capacity is DEPTH + 2.
    t0 = acc_total; p0 = pop_total;
    src_data = 8'h00; in_pct = 100; out_pct = 0; src_left = 30;
    wait_neg(40);
    check_eq("fill_count", 32'(acc_total - t0), 32'(DEPTH + 2));
    check_eq("fill_in_ready", 32'(in_ready), 32'd0);
    check_eq("fill_level", 32'(level), 32'(DEPTH + 2));
    check_eq("fill_head", 32'(out_data), 32'h00);
    src_left = 0; out_pct = 100;
    drain("fill_drain", 100);
    check_eq("fill_pops", 32'(pop_total - p0), 32'(DEPTH + 2));
    check_eq("fill_last", 32'(last_pop_data), 32'h11);

    // Streaming: one word per clock after fill, no gaps.
    p0 = pop_total;
    src_data = 8'h00; in_pct = 100; out_pct = 100; src_left = 100;
    wait_pops("tput_first", p0 + 1, 20);
    first_pop = last_pop_cyc;
    wait_pops("tput_all", p0 + 100, 200);
    check_eq("tput_span", 32'(last_pop_cyc - first_pop), 32'd99);
    check_eq("tput_last", 32'(last_pop_data), 32'h63);
    drain("tput_drain", 50);

    // Random traffic: producer-heavy then consumer-heavy.
    p0 = pop_total;
    src_data = 8'h00; in_pct = 70; out_pct = 40; src_left = 500;
    wait_pops("rand_a", p0 + 400, 4000);
    while (src_left != 0 && cyc < 200000) wait_neg(1);
    in_pct = 40; out_pct = 70; src_left = 500;
    wait_pops("rand_b", p0 + 1000, 6000);
    drain("rand_drain", 100);
    check_eq("rand_pops", 32'(pop_total - p0), 32'd1000);

    // Pointer wrap with periodic sink stalls.
    p0 = pop_total;
    src_data = 8'h80; in_pct = 100; out_pct = 0; stall_per = 4; src_left = 50;
    wait_pops("wrap_all", p0 + 50, 400);
    stall_per = 0; out_pct = 100;
    drain("wrap_drain", 50);
    check_eq("wrap_last", 32'(last_pop_data), 32'hB1);

    // Reset with level 10 and a read in flight.
    out_pct = 0; src_data = 8'h40; in_pct = 100; src_left = 11;
    wait_neg(30);
    check_eq("pre_rst_level11", 32'(level), 32'd11);
    out_pct = 100;
    wait_neg(1);
    out_pct = 0;
    wait_neg(1);
    check_eq("pre_rst_level10", 32'(level), 32'd10);
    reset = 1'b1;
    wait_neg(1);
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_level", 32'(level), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
    p0 = pop_total;
    src_data = 8'hC0; src_left = 3; out_pct = 100;
    reset = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
    wait_pops("post_rst_pop", p0 + 1, 20);
    check_eq("post_rst_first", 32'(last_pop_data), 32'hC0);
    drain("post_rst_drain", 50);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
